mem_stage: RTL and testbench

//   Memory stage of the ARM-style 5-stage pipeline. Directly downstream of the execute stage.

---
 rtl/mem_stage.sv | 125 ++++++++++++
 tb/tb_mem_stage.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory stage: EXE/MEM register, req/ack word-memory access for LDR/STR, and the
// MEM/WB register. Holds the upstream pipeline (freeze) while an access is in flight.
module mem_stage #(
  parameter logic [31:0] ADDR_BASE = 32'd1024,
  parameter int          ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exe_valid,
  input  logic              mem_read_en,
  input  logic              mem_write_en,
  input  logic              wb_en,
  input  logic [3:0]        dest,
  input  logic [31:0]       alu_res,
  input  logic [31:0]       val_Rm,
  output logic              freeze,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              wb_valid,
  output logic              wb_en_out,
  output logic              mem_read_out,
  output logic [3:0]        dest_out,
  output logic [31:0]       alu_res_out,
  output logic [31:0]       mem_data_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  typedef struct packed {
    logic        valid;
    logic        rd;
    logic        wr;
    logic        wb_en;
    logic [3:0]  dest;
    logic [31:0] alu_res;
    logic [31:0] val_rm;
  } exe_req_t;

  exe_req_t    req_q;
  state_t      state_q, state_d;
  logic        memop;
  logic        wb_load;
  logic [31:0] byte_off;

  assign memop    = req_q.valid & (req_q.rd | req_q.wr);
  assign byte_off = req_q.alu_res - ADDR_BASE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q   <= '0;
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
      if (!freeze) begin
        req_q.valid   <= exe_valid;
        req_q.rd      <= mem_read_en;
        req_q.wr      <= mem_write_en;
        req_q.wb_en   <= wb_en;
        req_q.dest    <= dest;
        req_q.alu_res <= alu_res;
        req_q.val_rm  <= val_Rm;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    freeze  = 1'b0;
    mem_req = 1'b0;
    wb_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (memop) begin
          freeze  = 1'b1;
          state_d = ACCESS;
        end else begin
          wb_load = 1'b1;
        end
      end
      ACCESS: begin
        freeze  = 1'b1;
        mem_req = 1'b1;
        if (mem_ack) state_d = DONE;
      end
      DONE: begin
        wb_load = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory-side outputs are gated by mem_req so they read 0 outside an access;
  // within ACCESS the input register is frozen, keeping them stable.
  assign mem_we    = mem_req & req_q.wr;
  assign mem_addr  = mem_req ? byte_off[ADDR_W+1:2] : '0;
  assign mem_wdata = mem_req ? req_q.val_rm : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid     <= 1'b0;
      wb_en_out    <= 1'b0;
      mem_read_out <= 1'b0;
      dest_out     <= '0;
      alu_res_out  <= '0;
      mem_data_out <= '0;
    end else begin
      // A set write enable wins over read, so only pure loads update load data.
      if (state_q == ACCESS && mem_ack && !req_q.wr)
        mem_data_out <= mem_rdata;
      if (wb_load) begin
        wb_valid     <= req_q.valid;
        wb_en_out    <= req_q.valid & req_q.wb_en;
        mem_read_out <= req_q.valid & req_q.rd;
        dest_out     <= req_q.dest;
        alu_res_out  <= req_q.alu_res;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, load/store handshakes, back-to-back
// hazard, async reset mid-access and stray acks. Expected values are hand-computed.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        exe_valid, mem_read_en, mem_write_en, wb_en;
  logic [3:0]  dest;
  logic [31:0] alu_res, val_Rm;
  logic        freeze, mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        wb_valid, wb_en_out, mem_read_out;
  logic [3:0]  dest_out;
  logic [31:0] alu_res_out, mem_data_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_stage #(.ADDR_BASE(32'd1024), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst),
    .exe_valid(exe_valid), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .wb_en(wb_en), .dest(dest), .alu_res(alu_res), .val_Rm(val_Rm),
    .freeze(freeze), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_en_out(wb_en_out), .mem_read_out(mem_read_out),
    .dest_out(dest_out), .alu_res_out(alu_res_out), .mem_data_out(mem_data_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rd, input logic wr, input logic we,
                       input logic [3:0] d, input logic [31:0] a, input logic [31:0] rm);
    exe_valid = v; mem_read_en = rd; mem_write_en = wr; wb_en = we;
    dest = d; alu_res = a; val_Rm = rm;
  endtask

  task automatic bubble();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
  endtask

  initial begin
    rst = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    bubble();
    #3;
    chk("rst_freeze", freeze, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_mdata", mem_data_out, 0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // ALU op: one cycle capture, next cycle on WB, no freeze
    drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 32'h55, 32'h0);
    tick();
    chk("alu_freeze", freeze, 0);
    bubble();
    tick();
    chk("alu_wb_valid", wb_valid, 1);
    chk("alu_wb_en", wb_en_out, 1);
    chk("alu_dest", dest_out, 3);
    chk("alu_res", alu_res_out, 32'h55);
    chk("alu_freeze2", freeze, 0);

    // Load at 1032, ack on the 3rd ACCESS cycle
    drive(1'b1, 1'b1, 1'b0, 1'b1, 4'd5, 32'd1032, 32'h0);
    tick();
    bubble();
    chk("ld_freeze0", freeze, 1);
    chk("ld_req0", mem_req, 0);
    tick();
    chk("ld_freeze1", freeze, 1);
    chk("ld_req1", mem_req, 1);
    chk("ld_addr", mem_addr, 2);
    chk("ld_we", mem_we, 0);
    tick();
    chk("ld_freeze2", freeze, 1);
    chk("ld_addr2", mem_addr, 2);
    tick();
    chk("ld_freeze3", freeze, 1);
    chk("ld_req3", mem_req, 1);
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    chk("ld_done_freeze", freeze, 0);
    chk("ld_done_req", mem_req, 0);
    chk("ld_done_wbv", wb_valid, 0);
    tick();
    chk("ld_wb_valid", wb_valid, 1);
    chk("ld_mdata", mem_data_out, 32'hDEADBEEF);
    chk("ld_mread", mem_read_out, 1);
    chk("ld_dest", dest_out, 5);
    chk("ld_wb_en", wb_en_out, 1);

    // Store at 1024, ack on the 1st ACCESS cycle
    drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd9, 32'd1024, 32'h1234);
    tick();
    bubble();
    chk("st_freeze0", freeze, 1);
    tick();
    chk("st_freeze1", freeze, 1);
    chk("st_req", mem_req, 1);
    chk("st_we", mem_we, 1);
    chk("st_addr", mem_addr, 0);
    chk("st_wdata", mem_wdata, 32'h1234);
    mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    chk("st_done_freeze", freeze, 0);
    tick();
    chk("st_wb_valid", wb_valid, 1);
    chk("st_wb_en", wb_en_out, 0);
    chk("st_mread", mem_read_out, 0);
    chk("st_mdata_kept", mem_data_out, 32'hDEADBEEF);

    // Load followed immediately by an ALU op held in EXE while frozen
    drive(1'b1, 1'b1, 1'b0, 1'b1, 4'd6, 32'd1036, 32'h0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd7, 32'h77, 32'h0);
    chk("b2b_freeze0", freeze, 1);
    tick();
    chk("b2b_addr", mem_addr, 3);
    mem_ack = 1'b1; mem_rdata = 32'h0000CAFE;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    chk("b2b_done_freeze", freeze, 0);
    tick();
    bubble();
    chk("b2b_ld_dest", dest_out, 6);
    chk("b2b_ld_mread", mem_read_out, 1);
    chk("b2b_ld_mdata", mem_data_out, 32'h0000CAFE);
    chk("b2b_ld_freeze", freeze, 0);
    tick();
    chk("b2b_alu_valid", wb_valid, 1);
    chk("b2b_alu_dest", dest_out, 7);
    chk("b2b_alu_res", alu_res_out, 32'h77);
    chk("b2b_alu_mread", mem_read_out, 0);
    tick();
    chk("b2b_no_dup", wb_valid, 0);

    // Async reset in the middle of an access
    drive(1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 32'd1040, 32'h0);
    tick();
    bubble();
    tick();
    chk("rma_req_before", mem_req, 1);
    #2 rst = 1'b0;
    #1;
    chk("rma_req", mem_req, 0);
    chk("rma_freeze", freeze, 0);
    chk("rma_addr", mem_addr, 0);
    chk("rma_mdata", mem_data_out, 0);
    chk("rma_dest", dest_out, 0);
    chk("rma_wb_valid", wb_valid, 0);
    #2 rst = 1'b1;
    tick();
    tick();
    chk("rma_post_valid", wb_valid, 0);
    chk("rma_post_req", mem_req, 0);
    chk("rma_post_freeze", freeze, 0);

    // Stray ack in IDLE and an invalid slot with read enable set
    drive(1'b0, 1'b1, 1'b0, 1'b1, 4'd4, 32'd1028, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'h11112222;
    tick();
    chk("stray_req", mem_req, 0);
    chk("stray_freeze", freeze, 0);
    mem_ack = 1'b0; mem_rdata = '0;
    tick();
    chk("stray_wb_valid", wb_valid, 0);
    chk("stray_wb_en", wb_en_out, 0);
    chk("stray_mread", mem_read_out, 0);
    chk("stray_mdata", mem_data_out, 0);
    chk("stray_req2", mem_req, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
